// File: rtl/gf2m_163_pkg.sv
// Shared constants and FSM encoding for the GF(2^163) reduction stage.
// Field is defined by the NIST B-163 pentanomial x^163 + x^7 + x^6 + x^3 + 1.
package gf2m_163_pkg;

    localparam int SIZE     = 163;
    localparam int M        = SIZE;
    localparam int TAIL_DEG = 7;
    localparam int PROD_W   = 2 * SIZE - 1;
    localparam int ACC_W    = SIZE + TAIL_DEG;
    localparam int HIGH1_W  = PROD_W - SIZE;
    localparam int HIGH2_W  = ACC_W - SIZE;

    // p(x) with the leading x^SIZE term removed.
    localparam logic [SIZE-1:0] POLY_TAIL = 163'hC9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FOLD1 = 2'd1,
        ST_FOLD2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gf2m_fold.sv
// Combinational fold: o_sum = i_low ^ (i_high * POLY_TAIL) over GF(2).
// The tail is a compile-time constant, so the product is a fixed XOR of shifted copies.
module gf2m_fold
    import gf2m_163_pkg::*;
#(
    parameter int LOW_W  = SIZE,
    parameter int HIGH_W = HIGH1_W,
    parameter int OUT_W  = ACC_W
) (
    input  logic [LOW_W-1:0]  i_low,
    input  logic [HIGH_W-1:0] i_high,
    output logic [OUT_W-1:0]  o_sum
);

    localparam int WIDE_W = max3(LOW_W, HIGH_W + TAIL_DEG, OUT_W);

    logic [WIDE_W-1:0] w_sum;

    // XOR the low part with one shifted copy of the high part per set tail bit.
    always_comb begin
        w_sum              = '0;
        w_sum[LOW_W-1:0]   = i_low;
        for (int k = 0; k <= TAIL_DEG; k++) begin
            if (POLY_TAIL[k]) begin
                w_sum = w_sum ^ (WIDE_W'(i_high) << k);
            end else begin
                w_sum = w_sum;
            end
        end
    end

    // When OUT_W < WIDE_W the dropped bits are zero by the tail-degree bound.
    assign o_sum = w_sum[OUT_W-1:0];

endmodule

// File: rtl/gf2m_reduce_163.sv
// Registered, handshaked reducer of a 325-bit carry-less product modulo the B-163
// pentanomial. Always runs two folds so latency is independent of the operand.
module gf2m_reduce_163
    import gf2m_163_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE-1:0]   r
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PROD_W-1:0]   r_prod;
    logic [ACC_W-1:0]    r_acc;
    logic [SIZE-1:0]     r_result;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                w_capture;
    logic [ACC_W-1:0]    w_fold1;
    logic [SIZE-1:0]     w_fold2;

    gf2m_fold #(
        .LOW_W  (SIZE),
        .HIGH_W (HIGH1_W),
        .OUT_W  (ACC_W)
    ) u_fold1 (
        .i_low  (r_prod[SIZE-1:0]),
        .i_high (r_prod[PROD_W-1:SIZE]),
        .o_sum  (w_fold1)
    );

    gf2m_fold #(
        .LOW_W  (SIZE),
        .HIGH_W (HIGH2_W),
        .OUT_W  (SIZE)
    ) u_fold2 (
        .i_low  (r_acc[SIZE-1:0]),
        .i_high (r_acc[ACC_W-1:SIZE]),
        .o_sum  (w_fold2)
    );

    // Next-state decode; DONE ignores in_valid until the consumer takes the result.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_FOLD1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FOLD1: w_state_nxt = ST_FOLD2;
            ST_FOLD2: w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and handshake flags; flags are decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Datapath registers, each loaded only in its own state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod   <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_capture) begin
                r_prod <= prod;
            end
            if (r_state == ST_FOLD1) begin
                r_acc <= w_fold1;
            end
            if (r_state == ST_FOLD2) begin
                r_result <= w_fold2;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign r         = r_result;

endmodule

// File: tb/tb_gf2m_reduce_163.sv
// Directed vectors, handshake corner cases and a randomized end-to-end check of
// gf2m_reduce_163 against a bit-serial GF(2^163) reference.
module tb_gf2m_reduce_163;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [324:0] prod = '0;
    logic         in_ready;
    logic         out_valid;
    logic [162:0] r;

    int n_tests = 0;
    int n_fail  = 0;

    gf2m_reduce_163 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [324:0] prod;
        logic [162:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [324:0] b325(input int i);
        logic [324:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [162:0] b163(input int i);
        logic [162:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [324:0] clmul(input logic [162:0] a, input logic [162:0] b);
        logic [324:0] acc;
        acc = '0;
        for (int i = 0; i < 163; i++) begin
            if (b[i]) acc = acc ^ (325'(a) << i);
        end
        return acc;
    endfunction

    // Schoolbook long division: clear bits from the top down using the full p(x).
    function automatic logic [162:0] reduce_ref(input logic [324:0] c);
        logic [324:0] t;
        logic [324:0] p;
        t = c;
        p = b325(163) | b325(7) | b325(6) | b325(3) | b325(0);
        for (int i = 324; i >= 163; i--) begin
            if (t[i]) t = t ^ (p << (i - 163));
        end
        return t[162:0];
    endfunction

    function automatic logic [162:0] rand163();
        logic [162:0] v;
        for (int k = 0; k < 163; k++) v[k] = 1'($urandom_range(1, 0));
        return v;
    endfunction

    task automatic chk(input string name, input logic [162:0] act, input logic [162:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction; called at posedge+1, returns at posedge+1.
    task automatic run_txn(input logic [324:0] p, output logic [162:0] res, output int lat);
        int n;
        n = 0;
        in_valid = 1'b1;
        prod     = p;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        res = r;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [162:0] res;
        int           lat;
        logic [162:0] a;
        logic [162:0] b;
        logic [324:0] p;
        logic [162:0] expq[$];
        int           accepts;
        int           results;
        int           last_acc;
        int           cyc;

        vecs[0].prod = b325(318) | b325(0);
        vecs[0].exp  = b163(162) | b163(161) | b163(158) | b163(155) | b163(0);
        vecs[1].prod = b325(324);
        vecs[1].exp  = b163(161) | b163(12) | b163(10) | b163(5) | b163(1);
        vecs[2].prod = b325(163);
        vecs[2].exp  = 163'hC9;
        vecs[3].prod = b325(162) | b325(0);
        vecs[3].exp  = b163(162) | b163(0);
        vecs[4].prod = '0;
        vecs[4].exp  = '0;
        vecs[5].prod = b325(169);
        vecs[5].exp  = b163(13) | b163(12) | b163(9) | b163(6);
        vecs[6].prod = b325(163) | b325(7) | b325(6) | b325(3) | b325(0);
        vecs[6].exp  = '0;
        vecs[7].prod = b325(200) | b325(100);
        vecs[7].exp  = b163(44) | b163(43) | b163(40) | b163(37) | b163(100);

        #12;
        chk("reset_in_ready", 163'(in_ready), 163'd1);
        chk("reset_out_valid", 163'(out_valid), 163'd0);
        chk("reset_r", r, 163'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].prod, res, lat);
            chk($sformatf("vec%0d_r", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 163'(lat), 163'd2);
        end

        // Backpressure: result must hold and a competing input must be ignored.
        chk("bp_in_ready_idle", 163'(in_ready), 163'd1);
        in_valid = 1'b1;
        prod     = b325(163);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("bp_out_valid_rise", 163'(out_valid), 163'd1);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            prod     = b325(324);
            @(posedge clk); #1;
            chk($sformatf("bp%0d_r", c), r, 163'hC9);
            chk($sformatf("bp%0d_out_valid", c), 163'(out_valid), 163'd1);
            chk($sformatf("bp%0d_in_ready", c), 163'(in_ready), 163'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_out_valid", 163'(out_valid), 163'd0);
        chk("bp_release_in_ready", 163'(in_ready), 163'd1);
        chk("bp_release_r", r, 163'hC9);
        run_txn(vecs[5].prod, res, lat);
        chk("bp_next_r", res, vecs[5].exp);

        // Asynchronous reset while in FOLD1, away from any clock edge.
        in_valid = 1'b1;
        prod     = b325(324);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", 163'(in_ready), 163'd1);
        chk("rst_mid_out_valid", 163'(out_valid), 163'd0);
        chk("rst_mid_r", r, 163'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_after_out_valid", 163'(out_valid), 163'd0);
        run_txn(vecs[1].prod, res, lat);
        chk("rst_after_r", res, vecs[1].exp);
        chk("rst_after_latency", 163'(lat), 163'd2);

        // Back-to-back random products with both handshakes held high.
        accepts  = 0;
        results  = 0;
        last_acc = -1;
        cyc      = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (results < 1000 && cyc < 5000) begin
            if (out_valid) begin
                if (expq.size() > 0) begin
                    chk($sformatf("rand%0d_r", results), r, expq.pop_front());
                    results++;
                end else begin
                    chk("rand_unexpected_out_valid", 163'(out_valid), 163'd0);
                end
            end
            if (in_ready) begin
                if (accepts < 1000) begin
                    a = rand163();
                    b = rand163();
                    p = clmul(a, b);
                    prod = p;
                    expq.push_back(reduce_ref(p));
                    if (last_acc >= 0) chk("rand_accept_interval", 163'(cyc - last_acc), 163'd4);
                    last_acc = cyc;
                    accepts++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rand_result_count", 163'(results), 163'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
